pipe_scoreboard: RTL and testbench

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 244 ++++++++++++++++++++++++
 tb/tb_pipe_scoreboard.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: hazard/scoreboard controller for a 5-stage in-order pipeline.
//
// It keeps shadow copies of the E, M and W pipeline registers and uses them to
// produce the stall/flush controls:
//   - load-use:     a load in E whose rd is read by the valid instruction in D
//                   stalls F/D for one cycle and turns E into a bubble.
//   - taken branch: PCSrcE clears the IF/ID and ID/EX registers and overrides
//                   any load-use stall in the same cycle.
//   - multiply:     a multiply sits in E for several cycles. The entry cycle and
//                   every BUSY cycle hold F/D/E and send bubbles into M.
//
// Parameters
//   MUL_LAT    E-stage latency of a multiply, 1..15. A value of 1 never stalls.
//
// Ports
//   clk        clock; all state changes on its rising edge
//   rst_n      asynchronous active-low reset
//   Rs1D/Rs2D  source registers of the instruction in D
//   RdD        destination register of the instruction in D
//   ValidD     D holds a real instruction
//   RegWriteD  D instruction writes the register file
//   LoadD      D instruction is a load
//   MulD       D instruction is a multiply
//   PCSrcE     taken branch/jump resolved in E
//   StallF     hold the PC
//   StallD     hold the IF/ID register
//   StallE     hold the ID/EX register
//   FlushD     clear the IF/ID register
//   FlushE     clear the ID/EX register
//   BubbleM    clear the EX/MEM register
//   RdE/M/W    destination of the instruction in E/M/W (0 when the stage is empty)
//   RegWriteM  qualified register-file write enable for M
//   RegWriteW  qualified register-file write enable for W
//   Busy       multiply state machine is in BUSY
module pipe_scoreboard #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       ValidD,
  input  logic       RegWriteD,
  input  logic       LoadD,
  input  logic       MulD,
  input  logic       PCSrcE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleM,
  output logic [4:0] RdE,
  output logic [4:0] RdM,
  output logic [4:0] RdW,
  output logic       RegWriteM,
  output logic       RegWriteW,
  output logic       Busy
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  // Full shadow of the instruction in E.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       load;
    logic       mul;
  } e_stage_t;

  // Load/mul only influence hazards while the instruction sits in E, so the
  // later stages carry just what the forwarding unit and write-back need.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } mw_stage_t;

  // The entry cycle is spent in IDLE, so BUSY runs MUL_LAT-1 cycles:
  // counter values MUL_LAT-2 down to 0.
  localparam bit         MulStalls = (MUL_LAT > 1);
  localparam logic [3:0] CntLoad   = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Set when BUSY ends: the multiply still held in E has completed and must
  // not start a new BUSY window. Cleared once E advances.
  logic       done_q, done_d;

  e_stage_t   e_q, e_d;
  mw_stage_t  m_q, m_d;
  mw_stage_t  w_q, w_d;

  logic load_use;
  logic mul_start;
  logic stall_f, stall_d, stall_e;
  logic flush_d, flush_e, bubble_m;

  // Hazard detection on the current E contents.
  always_comb begin
    load_use  = e_q.valid & e_q.load & (e_q.rd != 5'd0) & ValidD &
                ((e_q.rd == Rs1D) | (e_q.rd == Rs2D));
    mul_start = MulStalls & e_q.valid & e_q.mul & ~done_q;
  end

  // FSM: state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (mul_start) begin
          state_d = StBusy;
          cnt_d   = CntLoad;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM: outputs. Priority in IDLE: multiply entry > taken branch > load-use.
  always_comb begin
    stall_f  = 1'b0;
    stall_d  = 1'b0;
    stall_e  = 1'b0;
    flush_d  = 1'b0;
    flush_e  = 1'b0;
    bubble_m = 1'b0;
    case (state_q)
      StBusy: begin
        stall_f  = 1'b1;
        stall_d  = 1'b1;
        stall_e  = 1'b1;
        bubble_m = 1'b1;
      end
      StIdle: begin
        if (mul_start) begin
          stall_f  = 1'b1;
          stall_d  = 1'b1;
          stall_e  = 1'b1;
          bubble_m = 1'b1;
        end else if (PCSrcE) begin
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      default: begin
        stall_f = 1'b0;
      end
    endcase
    // Keep every output at 0 while reset is held, even if PCSrcE is driven.
    if (!rst_n) begin
      stall_f  = 1'b0;
      stall_d  = 1'b0;
      stall_e  = 1'b0;
      flush_d  = 1'b0;
      flush_e  = 1'b0;
      bubble_m = 1'b0;
    end
  end

  // Shadow stage next state.
  always_comb begin
    if (stall_e) begin
      e_d = e_q;
    end else if (flush_e) begin
      e_d = '0;
    end else begin
      e_d = '{valid: ValidD, rd: RdD, regwrite: RegWriteD, load: LoadD, mul: MulD};
    end

    if (bubble_m) begin
      m_d = '0;
    end else begin
      m_d = '{valid: e_q.valid, rd: e_q.rd, regwrite: e_q.regwrite};
    end

    w_d = m_q;

    if ((state_q == StBusy) && (cnt_q == 4'd0)) begin
      done_d = 1'b1;
    end else if (!stall_e) begin
      done_d = 1'b0;
    end else begin
      done_d = done_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q    <= '0;
      m_q    <= '0;
      w_q    <= '0;
      done_q <= 1'b0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_q    <= w_d;
      done_q <= done_d;
    end
  end

  assign StallF    = stall_f;
  assign StallD    = stall_d;
  assign StallE    = stall_e;
  assign FlushD    = flush_d;
  assign FlushE    = flush_e;
  assign BubbleM   = bubble_m;
  assign Busy      = (state_q == StBusy);

  assign RdE       = e_q.valid ? e_q.rd : 5'd0;
  assign RdM       = m_q.valid ? m_q.rd : 5'd0;
  assign RdW       = w_q.valid ? w_q.rd : 5'd0;
  assign RegWriteM = m_q.valid & m_q.regwrite & (m_q.rd != 5'd0);
  assign RegWriteW = w_q.valid & w_q.regwrite & (w_q.rd != 5'd0);

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed testbench for pipe_scoreboard (MUL_LAT=4 main instance plus a
// MUL_LAT=1 instance sharing the same stimulus for the no-stall case).
module tb_pipe_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       ValidD, RegWriteD, LoadD, MulD, PCSrcE;

  logic       StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy;
  logic [4:0] RdE, RdM, RdW;
  logic       RegWriteM, RegWriteW;

  logic       l1_StallF, l1_StallD, l1_StallE, l1_FlushD, l1_FlushE, l1_BubbleM, l1_Busy;
  logic [4:0] l1_RdE, l1_RdM, l1_RdW;
  logic       l1_RegWriteM, l1_RegWriteW;

  logic [6:0] ctrl, l1_ctrl;
  assign ctrl    = {StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy};
  assign l1_ctrl = {l1_StallF, l1_StallD, l1_StallE, l1_FlushD, l1_FlushE, l1_BubbleM, l1_Busy};

  // {StallF, StallD, StallE, FlushD, FlushE, BubbleM, Busy}
  localparam logic [6:0] CNone     = 7'b0000000;
  localparam logic [6:0] CLoadUse  = 7'b1100100;
  localparam logic [6:0] CBranch   = 7'b0001100;
  localparam logic [6:0] CMulEntry = 7'b1110010;
  localparam logic [6:0] CMulBusy  = 7'b1110011;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_scoreboard #(.MUL_LAT(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .MulD(MulD), .PCSrcE(PCSrcE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .FlushD(FlushD), .FlushE(FlushE),
    .BubbleM(BubbleM), .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .Busy(Busy)
  );

  pipe_scoreboard #(.MUL_LAT(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .ValidD(ValidD),
    .RegWriteD(RegWriteD), .LoadD(LoadD), .MulD(MulD), .PCSrcE(PCSrcE),
    .StallF(l1_StallF), .StallD(l1_StallD), .StallE(l1_StallE), .FlushD(l1_FlushD),
    .FlushE(l1_FlushE), .BubbleM(l1_BubbleM), .RdE(l1_RdE), .RdM(l1_RdM), .RdW(l1_RdW),
    .RegWriteM(l1_RegWriteM), .RegWriteW(l1_RegWriteW), .Busy(l1_Busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one D-stage instruction at the falling edge; checks follow at +1.
  task automatic cyc(input logic v, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic rw, input logic ld,
                     input logic mu, input logic pc);
    @(negedge clk);
    ValidD = v; RdD = rd; Rs1D = rs1; Rs2D = rs2;
    RegWriteD = rw; LoadD = ld; MulD = mu; PCSrcE = pc;
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ValidD = 1'b0; RdD = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
    RegWriteD = 1'b0; LoadD = 1'b0; MulD = 1'b0; PCSrcE = 1'b1;
    #3;
    check("rst_ctrl", ctrl, CNone);
    check("rst_rde", RdE, 0);
    check("rst_rdm", RdM, 0);
    check("rst_rdw", RdW, 0);
    check("rst_rw", {RegWriteM, RegWriteW}, 0);
    PCSrcE = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // lw x5 then add using x5 on rs1
    cyc(1, 5, 0, 0, 1, 1, 0, 0);
    check("lu_pre", ctrl, CNone);
    cyc(1, 6, 5, 0, 1, 0, 0, 0);
    check("lu_rs1_ctrl", ctrl, CLoadUse);
    check("lu_rde", RdE, 5);
    cyc(1, 6, 5, 0, 1, 0, 0, 0);
    check("lu_one_cycle", ctrl, CNone);
    check("lu_rdm", RdM, 5);
    check("lu_rwm", RegWriteM, 1);
    check("lu_e_bubble", RdE, 0);
    nop();
    check("lu_add_in_e", RdE, 6);
    check("lu_m_bubble_rw", RegWriteM, 0);
    check("lu_rdw", RdW, 5);
    check("lu_rww", RegWriteW, 1);

    // lw x0 never stalls and never writes
    cyc(1, 0, 0, 0, 1, 1, 0, 0);
    check("add_rdm", RdM, 6);
    cyc(1, 3, 0, 0, 1, 0, 0, 0);
    check("x0_nostall", ctrl, CNone);
    nop();
    check("x0_rdm", RdM, 0);
    check("x0_rwm", RegWriteM, 0);
    check("x0_next_rde", RdE, 3);

    // rs2 match
    cyc(1, 9, 0, 0, 1, 1, 0, 0);
    cyc(1, 10, 1, 9, 1, 0, 0, 0);
    check("lu_rs2_ctrl", ctrl, CLoadUse);
    cyc(1, 10, 1, 9, 1, 0, 0, 0);
    check("lu_rs2_release", ctrl, CNone);
    check("lu_rs2_rdm", RdM, 9);

    // match on an invalid D slot does not stall
    cyc(1, 4, 0, 0, 1, 1, 0, 0);
    check("lu_rs2_rdw", RdW, 9);
    cyc(0, 0, 4, 4, 0, 0, 0, 0);
    check("lu_validd_off", ctrl, CNone);

    // taken branch coincident with a load-use match
    cyc(1, 14, 0, 0, 1, 1, 0, 0);
    cyc(1, 11, 14, 0, 1, 0, 0, 1);
    check("br_over_lu", ctrl, CBranch);
    nop();
    check("br_after_ctrl", ctrl, CNone);
    check("br_e_flushed", RdE, 0);
    check("br_rdm", RdM, 14);

    // mul x7, MUL_LAT=4: entry cycle, then 3 BUSY cycles
    cyc(1, 7, 0, 0, 1, 0, 1, 0);
    check("mul_pre", ctrl, CNone);
    cyc(1, 12, 7, 0, 1, 0, 0, 0);
    check("mul_entry", ctrl, CMulEntry);
    check("mul_rde", RdE, 7);
    check("lat1_nostall", l1_ctrl, CNone);
    cyc(1, 12, 7, 0, 1, 0, 0, 1);
    check("mul_busy_br_ignored", ctrl, CMulBusy);
    check("lat1_rdm", l1_RdM, 7);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 12, 7, 0, 1, 0, 0, 0);
      check("mul_busy", ctrl, CMulBusy);
      check("mul_busy_rde", RdE, 7);
      check("mul_busy_rdm", RdM, 0);
    end
    cyc(1, 12, 7, 0, 1, 0, 0, 0);
    check("mul_release", ctrl, CNone);
    check("mul_release_rde", RdE, 7);

    // back-to-back mul x1, mul x2
    cyc(1, 1, 0, 0, 1, 0, 1, 0);
    check("mul_rdm", RdM, 7);
    check("mul_rwm", RegWriteM, 1);
    check("b2b_pre", ctrl, CNone);
    cyc(1, 2, 0, 0, 1, 0, 1, 0);
    check("b2b_entry1", ctrl, CMulEntry);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2, 0, 0, 1, 0, 1, 0);
      check("b2b_busy1", ctrl, CMulBusy);
    end
    cyc(1, 2, 0, 0, 1, 0, 1, 0);
    check("b2b_release1", ctrl, CNone);
    nop();
    check("b2b_entry2", ctrl, CMulEntry);
    check("b2b_rdm1", RdM, 1);
    for (int i = 0; i < 3; i++) begin
      nop();
      check("b2b_busy2", ctrl, CMulBusy);
      if (i == 0) check("b2b_rdw1", RdW, 1);
    end
    nop();
    check("b2b_release2", ctrl, CNone);
    check("b2b_rde2", RdE, 2);
    nop();
    check("b2b_rdm2", RdM, 2);
    nop();
    check("b2b_rdw2", RdW, 2);

    // asynchronous reset during the 2nd BUSY cycle
    cyc(1, 8, 0, 0, 1, 0, 1, 0);
    nop();
    check("rst_mul_entry", ctrl, CMulEntry);
    nop();
    check("rst_busy1", ctrl, CMulBusy);
    nop();
    check("rst_busy2", ctrl, CMulBusy);
    check("rst_busy2_rde", RdE, 8);
    #1 rst_n = 1'b0;
    #1;
    check("rst_async_ctrl", ctrl, CNone);
    check("rst_async_rde", RdE, 0);
    check("rst_async_rdm", RdM, 0);
    check("rst_async_rdw", RdW, 0);
    @(negedge clk);
    check("rst_held_ctrl", ctrl, CNone);
    rst_n = 1'b1;
    ValidD = 1'b1; RdD = 5'd5; Rs1D = 5'd0; Rs2D = 5'd0;
    RegWriteD = 1'b1; LoadD = 1'b1; MulD = 1'b0; PCSrcE = 1'b0;
    cyc(1, 6, 0, 5, 1, 0, 0, 0);
    check("post_rst_rde", RdE, 5);
    check("post_rst_lu", ctrl, CLoadUse);
    nop();
    check("post_rst_rdm", RdM, 5);
    check("post_rst_ctrl", ctrl, CNone);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
